// File: rtl/dx_multdiv_if.sv
// Operand/IR bundle from the D/X latch and the completion bundle toward the X/M latch
// of the iterative multiply/divide unit.
interface dx_multdiv_if;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] ir_in;
  logic        valid_in;
  logic        kill;
  logic        stall;
  logic [31:0] result;
  logic [31:0] result_ir;
  logic        done;
  logic        exception;

  modport master (
    output a_in, b_in, ir_in, valid_in, kill,
    input  stall, result, result_ir, done, exception
  );

  modport slave (
    input  a_in, b_in, ir_in, valid_in, kill,
    output stall, result, result_ir, done, exception
  );
endinterface

// File: rtl/dx_multdiv.sv
// Execute-stage iterative signed 32-bit multiply (shift-add) and divide (restoring),
// 32 iterations per operation, stalling the D/X latch while busy.
module dx_multdiv (
  input  logic        clk,
  input  logic        reset_n,
  dx_multdiv_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [31:0] ir_q, ir_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        divz_q, divz_d;
  logic        dovf_q, dovf_d;
  logic [31:0] result_q, result_d;
  logic [31:0] result_ir_q, result_ir_d;
  logic        exc_q, exc_d;
  logic        done_q, done_d;

  logic        is_mul_s, is_div_s, start_s, last_iter_s, stall_s;
  logic [63:0] prod_next_s, prod_signed_s;
  logic [31:0] rem_shift_s;
  logic [32:0] diff_s;
  logic [31:0] quo_next_s, quo_signed_s;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    mag32 = v[31] ? (32'd0 - v) : v;
  endfunction

  // Instruction decode and the start qualifier.
  always_comb begin
    is_mul_s    = (bus.ir_in[31:27] == 5'b00000) && (bus.ir_in[6:2] == 5'b00110);
    is_div_s    = (bus.ir_in[31:27] == 5'b00000) && (bus.ir_in[6:2] == 5'b00111);
    start_s     = bus.valid_in && (is_mul_s || is_div_s) && (state_q == ST_IDLE) && !bus.kill;
    last_iter_s = (cnt_q == 6'd31);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; kill aborts any non-idle state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = is_mul_s ? ST_MUL : ST_DIV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (bus.kill) begin
          state_d = ST_IDLE;
        end else if (last_iter_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; the hold request is combinational so the latch freezes in the start cycle.
  always_comb begin
    stall_s = start_s || (state_q == ST_MUL) || (state_q == ST_DIV);
  end

  // Single iteration of each datapath, plus final sign correction.
  always_comb begin
    prod_next_s   = prod_q + (mplier_q[0] ? mcand_q : 64'd0);
    prod_signed_s = sign_q ? (64'd0 - prod_next_s) : prod_next_s;
    rem_shift_s   = {rem_q[30:0], dvd_q[31]};
    diff_s        = {1'b0, rem_shift_s} - {1'b0, dvs_q};
    quo_next_s    = {dvd_q[30:0], ~diff_s[32]};
    quo_signed_s  = sign_q ? (32'd0 - quo_next_s) : quo_next_s;
  end

  // Datapath next-state: operand capture, iteration, and result commit on entry to DONE.
  always_comb begin
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    ir_d        = ir_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    divz_d      = divz_q;
    dovf_d      = dovf_q;
    result_d    = result_q;
    result_ir_d = result_ir_q;
    exc_d       = exc_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          cnt_d    = 6'd0;
          sign_d   = bus.a_in[31] ^ bus.b_in[31];
          ir_d     = bus.ir_in;
          mcand_d  = {32'd0, mag32(bus.a_in)};
          mplier_d = mag32(bus.b_in);
          prod_d   = 64'd0;
          dvd_d    = mag32(bus.a_in);
          dvs_d    = mag32(bus.b_in);
          rem_d    = 32'd0;
          divz_d   = (bus.b_in == 32'd0);
          dovf_d   = (bus.a_in == 32'h8000_0000) && (bus.b_in == 32'hFFFF_FFFF);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_MUL: begin
        cnt_d    = cnt_q + 6'd1;
        prod_d   = prod_next_s;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        if (last_iter_s && !bus.kill) begin
          result_d    = prod_signed_s[31:0];
          result_ir_d = ir_q;
          // The low word is exact only when bits 63..31 are a pure sign extension.
          exc_d       = !((&prod_signed_s[63:31]) || !(|prod_signed_s[63:31]));
          done_d      = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q + 6'd1;
        rem_d = diff_s[32] ? rem_shift_s : diff_s[31:0];
        dvd_d = quo_next_s;
        if (last_iter_s && !bus.kill) begin
          result_d    = divz_q ? 32'd0 : quo_signed_s;
          result_ir_d = ir_q;
          exc_d       = divz_q || dovf_q;
          done_d      = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      ST_DONE: done_d = 1'b0;
      default: done_d = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 6'd0;
      sign_q      <= 1'b0;
      ir_q        <= 32'd0;
      mcand_q     <= 64'd0;
      mplier_q    <= 32'd0;
      prod_q      <= 64'd0;
      dvd_q       <= 32'd0;
      dvs_q       <= 32'd0;
      rem_q       <= 32'd0;
      divz_q      <= 1'b0;
      dovf_q      <= 1'b0;
      result_q    <= 32'd0;
      result_ir_q <= 32'd0;
      exc_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      ir_q        <= ir_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      divz_q      <= divz_d;
      dovf_q      <= dovf_d;
      result_q    <= result_d;
      result_ir_q <= result_ir_d;
      exc_q       <= exc_d;
      done_q      <= done_d;
    end
  end

  assign bus.stall     = stall_s;
  assign bus.result    = result_q;
  assign bus.result_ir = result_ir_q;
  assign bus.done      = done_q;
  assign bus.exception = exc_q;

endmodule
